prime_capture_ctrl: RTL and testbench

Clocked, parametrised successor to the switch/pushbutton prime-entry logic on the board top level. Captures N_SLOTS switch values, one per debounced button press, then replays them one per press in a review phase. Optionally rejects non-prime entries using the existing primality ROM's output. It replaces button-edge clocking with a single system clock, a 2-flop synchroniser and a debouncer.

---
 rtl/prime_pkg.sv | 8 +
 rtl/button_conditioner.sv | 39 +++
 rtl/prime_capture_ctrl.sv | 68 ++++++
 tb/tb_prime_capture_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// prime_pkg: shared phase encoding and index-width helper for the prime capture controller
package prime_pkg;
  localparam logic PH_ENTRY  = 1'b0;
  localparam logic PH_REVIEW = 1'b1;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect an active-low raw button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_raw,
  output logic pressed_lvl,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, deb_q, pulse_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_n_raw;
      s2_q    <= s1_q;
      pulse_q <= 1'b0;
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        // accept the new level; only a fall to 0 (active-low press) pulses
        deb_q   <= s2_q;
        cnt_q   <= '0;
        pulse_q <= ~s2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  assign pressed_lvl = ~deb_q;
  assign press_pulse = pulse_q;
endmodule

// File: rtl/prime_capture_ctrl.sv
// prime_capture_ctrl: captures N_SLOTS switch values on debounced presses, then replays them
module prime_capture_ctrl
  import prime_pkg::*;
#(
  parameter int W               = 10,
  parameter int N_SLOTS         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REQUIRE_PRIME   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [W-1:0]                sw,
  input  logic                        push_butt,
  input  logic                        is_prime,
  output logic [W-1:0]                ledr,
  output logic                        ledg,
  output logic                        ledg2,
  output logic                        phase,
  output logic [idx_w(N_SLOTS)-1:0]   state,
  output logic                        reject,
  output logic [N_SLOTS*W-1:0]        slots
);
  localparam int IW = idx_w(N_SLOTS);
  localparam logic [IW-1:0] LAST = IW'(N_SLOTS - 1);
  logic press, accept, last;
  logic phase_q, reject_q;
  logic [IW-1:0] state_q;
  logic [N_SLOTS*W-1:0] slots_q;
  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .rst        (rst),
    .btn_n_raw  (push_butt),
    .pressed_lvl(ledg2),
    .press_pulse(press)
  );
  assign accept = (REQUIRE_PRIME == 0) || is_prime;
  assign last   = state_q == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_ENTRY;
      state_q  <= '0;
      slots_q  <= '0;
      reject_q <= 1'b0;
    end else if (press) begin
      if (phase_q == PH_REVIEW) begin
        reject_q <= 1'b0;
        phase_q  <= last ? PH_ENTRY : PH_REVIEW;
        state_q  <= last ? '0 : state_q + IW'(1);
        if (last) slots_q <= '0;
      end else if (accept) begin
        slots_q[state_q*W +: W] <= sw;
        reject_q <= 1'b0;
        phase_q  <= last ? PH_REVIEW : PH_ENTRY;
        state_q  <= last ? '0 : state_q + IW'(1);
      end else begin
        reject_q <= 1'b1;
      end
    end
  end
  assign ledr   = (phase_q == PH_REVIEW) ? slots_q[state_q*W +: W] : sw;
  assign ledg   = (phase_q == PH_ENTRY) && is_prime;
  assign phase  = phase_q;
  assign state  = state_q;
  assign reject = reject_q;
  assign slots  = slots_q;
endmodule

// File: tb/tb_prime_capture_ctrl.sv
// tb_prime_capture_ctrl: randomized and directed checks against a window-based behavioural model
module tb_prime_capture_ctrl;
  localparam int W = 10, N = 2, DB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic push_butt = 1'b1, is_prime = 1'b0;
  logic [W-1:0] ledr;
  logic ledg, ledg2, phase, reject;
  logic [0:0] state;
  logic [N*W-1:0] slots;
  logic [7:0] sw_b = '0;
  logic pb_b = 1'b1, ip_b = 1'b0;
  logic [7:0] ledr_b;
  logic ledg_b, ledg2_b, phase_b, reject_b;
  logic [1:0] state_b;
  logic [23:0] slots_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  prime_capture_ctrl #(.W(W), .N_SLOTS(N), .DEBOUNCE_CYCLES(DB), .REQUIRE_PRIME(1)) dut (
    .clk(clk), .rst(rst), .sw(sw), .push_butt(push_butt), .is_prime(is_prime),
    .ledr(ledr), .ledg(ledg), .ledg2(ledg2), .phase(phase), .state(state),
    .reject(reject), .slots(slots));

  prime_capture_ctrl #(.W(8), .N_SLOTS(3), .DEBOUNCE_CYCLES(DB), .REQUIRE_PRIME(0)) dut_b (
    .clk(clk), .rst(rst), .sw(sw_b), .push_butt(pb_b), .is_prime(ip_b),
    .ledr(ledr_b), .ledg(ledg_b), .ledg2(ledg2_b), .phase(phase_b), .state(state_b),
    .reject(reject_b), .slots(slots_b));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  // Model: the debounced level flips once the last DB synchronised samples all disagree with it.
  bit rq[$], sq[$];
  bit m_deb, m_pend, m_phase, m_reject, m_valid = 1'b0, all_diff;
  int m_state;
  logic [W-1:0] m_slot [N];
  always @(posedge clk) begin
    if (rst) begin
      rq = {1'b1, 1'b1};
      sq = {};
      m_deb = 1'b1; m_pend = 1'b0; m_phase = 1'b0; m_state = 0; m_reject = 1'b0; m_valid = 1'b1;
      foreach (m_slot[i]) m_slot[i] = '0;
    end else if (m_valid) begin
      if (m_pend) begin
        if (!m_phase) begin
          if (is_prime) begin
            m_slot[m_state] = sw;
            m_reject = 1'b0;
            m_state = (m_state + 1) % N;
            if (m_state == 0) m_phase = 1'b1;
          end else m_reject = 1'b1;
        end else begin
          m_reject = 1'b0;
          m_state = (m_state + 1) % N;
          if (m_state == 0) begin
            m_phase = 1'b0;
            foreach (m_slot[i]) m_slot[i] = '0;
          end
        end
      end
      sq.push_back(rq[0]);
      if (sq.size() > DB) void'(sq.pop_front());
      rq.push_back(push_butt);
      void'(rq.pop_front());
      m_pend = 1'b0;
      all_diff = (sq.size() == DB);
      foreach (sq[i]) if (sq[i] == m_deb) all_diff = 1'b0;
      if (all_diff) begin
        m_deb = ~m_deb;
        m_pend = !m_deb;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("phase", phase, m_phase);
      chk("state", state, m_state);
      chk("slots", slots, {m_slot[1], m_slot[0]});
      chk("reject", reject, m_reject);
      chk("ledg2", ledg2, !m_deb);
      chk("ledg", ledg, !m_phase && is_prime);
      chk("ledr", ledr, m_phase ? m_slot[m_state] : sw);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [W-1:0] v, input logic p, input int lo, input int hi);
    sw = v; is_prime = p; push_butt = 1'b0;
    cyc(lo);
    push_butt = 1'b1;
    cyc(hi);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    cyc(2);
    rst = 1'b0;
    sw = 10'd37; is_prime = 1'b1;
    cyc(3);
    chk("rst_phase", phase, 0);
    chk("rst_state", state, 0);
    chk("rst_slots", slots, 0);
    chk("rst_reject", reject, 0);
    chk("rst_ledg2", ledg2, 0);
    chk("idle_ledr", ledr, 37);
    chk("idle_ledg", ledg, 1);
    sw = 10'd7; is_prime = 1'b1; push_butt = 1'b0;
    cyc(10);
    chk("held_ledg2", ledg2, 1);
    push_butt = 1'b1;
    cyc(10);
    chk("rel_ledg2", ledg2, 0);
    chk("p1_slot0", slots[9:0], 7);
    chk("p1_state", state, 1);
    press(10'd11, 1'b1, 10, 10);
    chk("p2_slot1", slots[19:10], 11);
    chk("p2_phase", phase, 1);
    chk("p2_state", state, 0);
    chk("p2_ledr", ledr, 7);
    chk("p2_ledg", ledg, 0);
    press(10'd100, 1'b0, 10, 10);
    chk("p3_ledr", ledr, 11);
    chk("p3_state", state, 1);
    press(10'd200, 1'b1, 10, 10);
    chk("p4_phase", phase, 0);
    chk("p4_state", state, 0);
    chk("p4_slots", slots, 0);
    press(10'd9, 1'b0, 10, 10);
    chk("rej_reject", reject, 1);
    chk("rej_state", state, 0);
    chk("rej_slot0", slots[9:0], 0);
    press(10'd5, 1'b1, 10, 10);
    chk("acc_slot0", slots[9:0], 5);
    chk("acc_reject", reject, 0);
    chk("acc_state", state, 1);
    press(10'd3, 1'b1, 2, 10);
    chk("glitch_state", state, 1);
    chk("glitch_phase", phase, 0);
    press(10'd3, 1'b1, 6, 10);
    chk("edge_phase", phase, 1);
    chk("edge_slot1", slots[19:10], 3);
    sw = 10'd13; is_prime = 1'b1; push_butt = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(12);
    chk("midrst_slots", slots, 13);
    chk("midrst_state", state, 1);
    push_butt = 1'b1;
    cyc(10);
    sw = 10'd17; push_butt = 1'b0;
    n = 0;
    while (!m_pend && n < 40) begin
      cyc(1);
      n++;
    end
    chk("pend_timeout", 32'(n < 40), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    push_butt = 1'b1;
    chk("coin_state", state, 0);
    chk("coin_slots", slots, 0);
    chk("coin_phase", phase, 0);
    cyc(10);
    chk("coin_after", slots, 0);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      press(W'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 12), $urandom_range(1, 12));
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    foreach (sw_b[i]) sw_b[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw_b = 8'(4 + 2 * i); ip_b = 1'b0; pb_b = 1'b0;
      cyc(10);
      pb_b = 1'b1;
      cyc(10);
      if (i == 0) begin
        chk("b_state1", state_b, 1);
        chk("b_slot0", slots_b[7:0], 4);
      end
    end
    chk("b_slots", slots_b, 24'h080604);
    chk("b_phase", phase_b, 1);
    chk("b_state", state_b, 0);
    chk("b_ledr", ledr_b, 4);
    chk("b_reject", reject_b, 0);
    chk("b_ledg", ledg_b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
